// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-style add/subtract.
// Align, add, normalise one shift per cycle, round to nearest-even.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic [3:0]   flags
);
  localparam int SW = MAN_W + 3;
  localparam int MW = MAN_W + 5;
  localparam int EW = EXP_W + 1;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, ALIGN, ADD, NORM, ROUND, OUT
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]    a_q, b_q;
  logic            op_q;
  logic            sx_q, sy_q, stk_q;
  logic [EW-1:0]   e_q;
  logic [SW-1:0]   mx_q, my_q;
  logic [MW-1:0]   m_q;
  logic [W-1:0]    res_q;
  logic [3:0]      flags_q;

  logic [EXP_W-1:0] ea, eb, ex, ey, d;
  logic [MAN_W-1:0] fa, fb, rfrac;
  logic             za, zb, sa, sb, swap;
  logic             nan_a, nan_b, inf_a, inf_b;
  logic             special, inc, inexact;
  logic [W-2:0]     mag_a, mag_b;
  logic [SW-1:0]    sig_a, sig_b;
  logic [31:0]      sh;
  logic [2*SW-1:0]  wide;
  logic [MW-1:0]    xe, ye, sum;
  logic [W-1:0]     spec_res, rnd_res;
  logic [3:0]       spec_flg, rnd_flg;
  logic             n_zero, n_rsh, n_den, n_uf, n_lsh;
  logic [MAN_W+1:0] rsum;
  logic [EW-1:0]    re;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign res       = res_q;
  assign flags     = flags_q;

  // operand decode, alignment, add, normalise and round datapath
  always_comb begin
    ea = a_q[W-2:MAN_W];
    eb = b_q[W-2:MAN_W];
    fa = a_q[MAN_W-1:0];
    fb = b_q[MAN_W-1:0];
    za = (ea == '0);
    zb = (eb == '0);
    sa = a_q[W-1];
    sb = b_q[W-1] ^ op_q;
    nan_a = (ea == EMAX) && (fa != '0);
    nan_b = (eb == EMAX) && (fb != '0);
    inf_a = (ea == EMAX) && (fa == '0);
    inf_b = (eb == EMAX) && (fb == '0);
    special = nan_a | nan_b | inf_a | inf_b;
    mag_a = za ? '0 : a_q[W-2:0];
    mag_b = zb ? '0 : b_q[W-2:0];
    swap  = (mag_b > mag_a);
    sig_a = za ? '0 : {1'b1, fa, 2'b00};
    sig_b = zb ? '0 : {1'b1, fb, 2'b00};
    ex = swap ? (zb ? '0 : eb) : (za ? '0 : ea);
    ey = swap ? (za ? '0 : ea) : (zb ? '0 : eb);
    d  = ex - ey;
    sh = (32'(d) >= 32'(SW)) ? 32'(SW) : 32'(d);
    wide = {(swap ? sig_a : sig_b), {SW{1'b0}}} >> sh;
    xe = {1'b0, mx_q, 1'b0};
    ye = {1'b0, my_q, stk_q};
    sum = (sx_q == sy_q) ? xe + ye : xe - ye;
    spec_flg = 4'b0000;
    if (nan_a || nan_b) begin
      spec_res = QNAN;
    end else if (inf_a && inf_b && (sa != sb)) begin
      spec_res = QNAN;
      spec_flg = 4'b1000;
    end else if (inf_a) begin
      spec_res = {sa, EMAX, {MAN_W{1'b0}}};
    end else begin
      spec_res = {sb, EMAX, {MAN_W{1'b0}}};
    end
    n_zero = (m_q == '0);
    n_rsh  = !n_zero && m_q[MW-1];
    n_den  = !n_zero && !m_q[MW-1] && !m_q[MW-2];
    n_uf   = n_den && (e_q <= EW'(1));
    n_lsh  = n_den && !n_uf;
    inc  = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    inexact = m_q[2] | m_q[1] | m_q[0];
    rsum = {1'b0, m_q[MW-2:3]} + (MAN_W+2)'(inc);
    re   = e_q + EW'(rsum[MAN_W+1]);
    rfrac = rsum[MAN_W+1] ? rsum[MAN_W:1] : rsum[MAN_W-1:0];
    if (re >= {1'b0, EMAX}) begin
      rnd_res = {sx_q, EMAX, {MAN_W{1'b0}}};
      rnd_flg = 4'b0101;
    end else begin
      rnd_res = {sx_q, re[EXP_W-1:0], rfrac};
      rnd_flg = {3'b000, inexact};
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (in_valid) state_d = ALIGN;
      ALIGN: state_d = ADD;
      ADD:   state_d = special ? OUT : NORM;
      NORM: begin
        if (n_zero || n_uf)      state_d = OUT;
        else if (!n_rsh && !n_lsh) state_d = ROUND;
      end
      ROUND: state_d = OUT;
      OUT:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath registers advanced per state
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; op_q <= 1'b0;
      sx_q <= 1'b0; sy_q <= 1'b0; stk_q <= 1'b0;
      e_q <= '0; mx_q <= '0; my_q <= '0;
      m_q <= '0; res_q <= '0; flags_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_q  <= a;
          b_q  <= b;
          op_q <= op;
        end
        ALIGN: begin
          sx_q  <= swap ? sb : sa;
          sy_q  <= swap ? sa : sb;
          e_q   <= {1'b0, ex};
          mx_q  <= swap ? sig_b : sig_a;
          my_q  <= wide[2*SW-1:SW];
          stk_q <= |wide[SW-1:0];
        end
        ADD: begin
          if (special) begin
            res_q   <= spec_res;
            flags_q <= spec_flg;
          end else begin
            m_q <= sum;
          end
        end
        NORM: begin
          if (n_zero) begin
            res_q   <= {sx_q & sy_q, {(W-1){1'b0}}};
            flags_q <= 4'b0000;
          end else if (n_rsh) begin
            m_q <= {1'b0, m_q[MW-1:2], m_q[1] | m_q[0]};
            e_q <= e_q + EW'(1);
          end else if (n_uf) begin
            res_q   <= {sx_q, {(W-1){1'b0}}};
            flags_q <= 4'b0011;
          end else if (n_lsh) begin
            m_q <= {m_q[MW-2:0], 1'b0};
            e_q <= e_q - EW'(1);
          end
        end
        ROUND: begin
          res_q   <= rnd_res;
          flags_q <= rnd_flg;
        end
        default: ;
      endcase
    end
  end

endmodule
